// File: rtl/matmul_result_store.sv
// rtl/matmul_result_store.sv - scratchpad capture/readback of systolic multiplier results
// Optional feature macro: OVF_STICKY_EN (overflow flags accumulate across captures)
module matmul_result_store #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUS_WIDTH   = 16,
  parameter int SP_NTARGETS = 4,
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  localparam int NFLAG      = MAX_DIM * MAX_DIM,
  localparam int MAT_W      = NFLAG * BUS_WIDTH,
  localparam int SLOT_W     = $clog2(SP_NTARGETS),
  localparam int IDX_W      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   finish_mul_i,
  input  logic [MAT_W-1:0]       c_matrix_i,
  input  logic [NFLAG-1:0]       flags_i,
  input  logic [SLOT_W-1:0]      wr_target_i,
  input  logic [SLOT_W-1:0]      rd_target_i,
  input  logic                   clear_i,
  input  logic                   rd_en_i,
  input  logic [SLOT_W-1:0]      rd_slot_i,
  input  logic [IDX_W-1:0]       rd_row_i,
  input  logic [IDX_W-1:0]       rd_col_i,
  output logic [BUS_WIDTH-1:0]   rd_data_o,
  output logic                   rd_valid_o,
  output logic [MAT_W-1:0]       c_matrix_o,
  output logic [NFLAG-1:0]       flags_o,
  output logic                   finish_write_o,
  output logic [SP_NTARGETS-1:0] slot_valid_o
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e                 state_q, state_d;
  logic                   fin_q;
  logic                   capture;
  logic [MAT_W-1:0]       slot_q [SP_NTARGETS];
  logic [MAT_W-1:0]       slot_d [SP_NTARGETS];
  logic [SP_NTARGETS-1:0] valid_q, valid_d;
  logic [NFLAG-1:0]       flags_q, flags_d, flags_base;
  logic [BUS_WIDTH-1:0]   rd_data_q, rd_data_d, rd_elem;
  logic                   rd_valid_q, rd_valid_d;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: one capture per finish_mul_i high period, wait in HOLD for it to drop
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (finish_mul_i && !fin_q) state_d = HOLD;
      HOLD: if (!finish_mul_i)          state_d = IDLE;
    endcase
  end

  // FSM outputs: capture strobe on the finish rise, write-done held through HOLD
  always_comb begin
    capture        = 1'b0;
    finish_write_o = 1'b0;
    case (state_q)
      IDLE: capture        = finish_mul_i && !fin_q;
      HOLD: finish_write_o = 1'b1;
    endcase
  end

  // Storage update: clear first, then the capture sets its own valid bit and flags
  always_comb begin
    slot_d     = slot_q;
    valid_d    = clear_i ? '0 : valid_q;
    flags_base = clear_i ? '0 : flags_q;
    flags_d    = flags_base;
    if (capture) begin
      slot_d[wr_target_i]  = c_matrix_i;
      valid_d[wr_target_i] = 1'b1;
`ifdef OVF_STICKY_EN
      flags_d = flags_base | flags_i;
`else
      flags_d = flags_i;
`endif
    end
  end

  // Element read from pre-update contents; invalid slot or out-of-range index reads 0
  always_comb begin
    rd_elem = '0;
    for (int r = 0; r < MAX_DIM; r++) begin
      for (int c = 0; c < MAX_DIM; c++) begin
        if (int'(rd_row_i) == r && int'(rd_col_i) == c)
          rd_elem = slot_q[rd_slot_i][(c*MAX_DIM+r)*BUS_WIDTH +: BUS_WIDTH];
      end
    end
    rd_valid_d = rd_en_i;
    rd_data_d  = rd_data_q;
    if (rd_en_i) rd_data_d = valid_q[rd_slot_i] ? rd_elem : '0;
  end

  // Datapath registers: edge detect, slots, valid bits, flags, read port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fin_q      <= 1'b0;
      slot_q     <= '{default: '0};
      valid_q    <= '0;
      flags_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      fin_q      <= finish_mul_i;
      slot_q     <= slot_d;
      valid_q    <= valid_d;
      flags_q    <= flags_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign flags_o      = flags_q;
  assign slot_valid_o = valid_q;
  assign c_matrix_o   = valid_q[rd_target_i] ? slot_q[rd_target_i] : '0;

endmodule

// File: tb/tb_matmul_result_store.sv
// tb/tb_matmul_result_store.sv - scoreboard bench for matmul_result_store
module tb_matmul_result_store;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        finish_mul_i;
  logic [63:0] c_matrix_i;
  logic [3:0]  flags_i;
  logic [1:0]  wr_target_i, rd_target_i, rd_slot_i;
  logic        clear_i, rd_en_i;
  logic [0:0]  rd_row_i, rd_col_i;
  logic [15:0] rd_data_o;
  logic        rd_valid_o;
  logic [63:0] c_matrix_o;
  logic [3:0]  flags_o;
  logic        finish_write_o;
  logic [3:0]  slot_valid_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] rd_exp_q [$];

  matmul_result_store dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .finish_mul_i(finish_mul_i),
    .c_matrix_i(c_matrix_i), .flags_i(flags_i), .wr_target_i(wr_target_i),
    .rd_target_i(rd_target_i), .clear_i(clear_i), .rd_en_i(rd_en_i),
    .rd_slot_i(rd_slot_i), .rd_row_i(rd_row_i), .rd_col_i(rd_col_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .c_matrix_o(c_matrix_o),
    .flags_o(flags_o), .finish_write_o(finish_write_o), .slot_valid_o(slot_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive a one-cycle read request and record the expected element
  task automatic bus_read(input logic [1:0] slot, input logic r, input logic c, input logic [15:0] exp);
    rd_en_i   = 1'b1;
    rd_slot_i = slot;
    rd_row_i  = r;
    rd_col_i  = c;
    rd_exp_q.push_back(exp);
    tick();
    rd_en_i = 1'b0;
  endtask

  // Read monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk_i) begin
    if (rd_valid_o === 1'b1) begin
      if (rd_exp_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
      else check("rd_data", {48'd0, rd_data_o}, {48'd0, rd_exp_q.pop_front()});
    end
  end

  logic [3:0] exp_flags;

  initial begin
    rst_ni = 1'b0; finish_mul_i = 1'b0; c_matrix_i = '0; flags_i = '0;
    wr_target_i = '0; rd_target_i = '0; clear_i = 1'b0; rd_en_i = 1'b0;
    rd_slot_i = '0; rd_row_i = '0; rd_col_i = '0;
    tick(); tick();
    check("rst_valid", {60'd0, slot_valid_o}, 64'd0);
    check("rst_flags", {60'd0, flags_o}, 64'd0);
    check("rst_fw", {63'd0, finish_write_o}, 64'd0);
    check("rst_rdv", {63'd0, rd_valid_o}, 64'd0);
    check("rst_rdd", {48'd0, rd_data_o}, 64'd0);
    rst_ni = 1'b1;
    tick();

    // Basic capture into slot 2, element (1,0) = 00FF
    c_matrix_i = 64'h0000_0000_00FF_0000; wr_target_i = 2'd2; finish_mul_i = 1'b1;
    tick();
    check("cap_valid", {60'd0, slot_valid_o}, 64'h4);
    check("cap_fw", {63'd0, finish_write_o}, 64'd1);
    tick(); tick();
    check("hold_fw", {63'd0, finish_write_o}, 64'd1);
    finish_mul_i = 1'b0;
    tick();
    check("drop_fw", {63'd0, finish_write_o}, 64'd0);
    rd_target_i = 2'd2; #1;
    check("cmat_s2", c_matrix_o, 64'h0000_0000_00FF_0000);
    bus_read(2'd2, 1'b1, 1'b0, 16'h00FF);
    tick(); tick();
    check("rd_hold_v", {63'd0, rd_valid_o}, 64'd0);
    check("rd_hold_d", {48'd0, rd_data_o}, 64'h00FF);

    // Finish held 5 cycles while wr_target_i wanders: one capture into slot 1
    c_matrix_i = 64'h4444_3333_2222_1111; wr_target_i = 2'd1; finish_mul_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      wr_target_i = (i % 2 == 0) ? 2'd3 : 2'd0;
      tick();
    end
    finish_mul_i = 1'b0;
    tick();
    check("one_cap_valid", {60'd0, slot_valid_o}, 64'h6);
    bus_read(2'd1, 1'b0, 1'b1, 16'h3333);
    bus_read(2'd1, 1'b1, 1'b1, 16'h4444);
    bus_read(2'd1, 1'b0, 1'b0, 16'h1111);

    // Unwritten slot 3
    bus_read(2'd3, 1'b0, 1'b0, 16'h0000);
    rd_target_i = 2'd3; #1;
    check("cmat_empty", c_matrix_o, 64'd0);

    // Slot 0 gets 0005, then same-edge read and capture of 0009
    c_matrix_i = 64'h0000_0000_0000_0005; flags_i = 4'b0001; wr_target_i = 2'd0; finish_mul_i = 1'b1;
    tick();
    check("flags_first", {60'd0, flags_o}, 64'h1);
    finish_mul_i = 1'b0;
    tick();
    c_matrix_i = 64'h0000_0000_0000_0009; flags_i = 4'b1000; finish_mul_i = 1'b1;
    bus_read(2'd0, 1'b0, 1'b0, 16'h0005);
    finish_mul_i = 1'b0;
    tick();
`ifdef OVF_STICKY_EN
    exp_flags = 4'b1001;
`else
    exp_flags = 4'b1000;
`endif
    check("flags_second", {60'd0, flags_o}, {60'd0, exp_flags});
    bus_read(2'd0, 1'b0, 1'b0, 16'h0009);
    check("valid_pre_clr", {60'd0, slot_valid_o}, 64'h7);

    // Clear wipes valid bits and flags; data reads back as 0
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clr_flags", {60'd0, flags_o}, 64'd0);
    check("clr_valid", {60'd0, slot_valid_o}, 64'd0);
    rd_target_i = 2'd0; #1;
    check("clr_cmat", c_matrix_o, 64'd0);
    bus_read(2'd0, 1'b0, 1'b0, 16'h0000);

    // Reset mid-HOLD, then finish still high triggers a fresh capture
    c_matrix_i = 64'hAAAA_0000_0000_0000; flags_i = 4'b0110; wr_target_i = 2'd1; finish_mul_i = 1'b1;
    tick();
    check("pre_rst_fw", {63'd0, finish_write_o}, 64'd1);
    check("pre_rst_valid", {60'd0, slot_valid_o}, 64'h2);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_fw", {63'd0, finish_write_o}, 64'd0);
    check("arst_valid", {60'd0, slot_valid_o}, 64'd0);
    check("arst_flags", {60'd0, flags_o}, 64'd0);
    check("arst_rdd", {48'd0, rd_data_o}, 64'd0);
    tick();
    c_matrix_i = 64'hBBBB_0000_0000_0000; wr_target_i = 2'd3; flags_i = 4'b0010;
    rst_ni = 1'b1;
    tick();
    check("rel_fw", {63'd0, finish_write_o}, 64'd1);
    check("rel_valid", {60'd0, slot_valid_o}, 64'h8);
    check("rel_flags", {60'd0, flags_o}, 64'h2);
    finish_mul_i = 1'b0;
    bus_read(2'd3, 1'b1, 1'b1, 16'hBBBB);
    check("rel_drop_fw", {63'd0, finish_write_o}, 64'd0);

    tick(); tick(); tick();
    check("sb_drain", 64'(rd_exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_result_store.md
Name: matmul_result_store

Overview:
- Downstream stage of the systolic matrix multiplier.
- Captures the multiplier's packed result matrix and overflow flags into one of SP_NTARGETS scratchpad slots when multiplication finishes, then signals write completion back to control.
- Serves element-wise bus reads of stored results.
- Feeds a selected slot back as the C operand for accumulate (mode_bit) operations.

Parameters:
- DATA_WIDTH, 8, operand element width.
- BUS_WIDTH, 16, result element and read-data width.
- SP_NTARGETS, 4, number of scratchpad slots (power of 2, >=2).
- Derived, not overridable: MAX_DIM = BUS_WIDTH/DATA_WIDTH; MAT_W = MAX_DIM*MAX_DIM*BUS_WIDTH; SLOT_W = clog2(SP_NTARGETS); IDX_W = clog2(MAX_DIM), minimum 1.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- finish_mul_i  input  1  multiplier done; level, held high until start drops.
- c_matrix_i  input  MAT_W  packed result from the multiplier.
- flags_i  input  MAX_DIM*MAX_DIM  per-PE overflow flags.
- wr_target_i  input  SLOT_W  slot receiving the next capture.
- rd_target_i  input  SLOT_W  slot driven on c_matrix_o.
- clear_i  input  1  synchronous clear of all valid bits and flags.
- rd_en_i  input  1  bus element read request.
- rd_slot_i  input  SLOT_W  read slot.
- rd_row_i  input  IDX_W  read row.
- rd_col_i  input  IDX_W  read column.
- rd_data_o  output  BUS_WIDTH  read element, registered.
- rd_valid_o  output  1  read-data strobe.
- c_matrix_o  output  MAT_W  slot rd_target_i, fed to the multiplier's C input.
- flags_o  output  MAX_DIM*MAX_DIM  overflow status.
- finish_write_o  output  1  capture complete, fed to control.
- slot_valid_o  output  SP_NTARGETS  per-slot valid bits.

Behaviour:
- Element packing, identical to the multiplier: element (r,c) occupies bits [(c*MAX_DIM+r+1)*BUS_WIDTH-1 -: BUS_WIDTH]. Flag (r,c) is bit r+c*MAX_DIM.
- Reset (async, rst_ni=0), all cleared immediately: FSM=IDLE; all slots=0; slot_valid_o=0; flags_o=0; rd_data_o=0; rd_valid_o=0; finish_write_o=0; finish_mul_i edge-detect register=0.
- FSM states IDLE, HOLD.
  - IDLE: on the first cycle finish_mul_i=1 (rising edge vs registered copy), at that clock edge:
    - slot[wr_target_i] <= c_matrix_i;
    - slot_valid_o[wr_target_i] <= 1;
    - flags update per Optional Feature;
    - finish_write_o <= 1; go to HOLD.
  - HOLD: finish_write_o stays 1. When finish_mul_i=0, finish_write_o <= 0 and go to IDLE.
  - Exactly one capture per finish_mul_i high period. Capture latency: 1 cycle from the finish rise to data visible.
- wr_target_i and c_matrix_i are sampled only on the capture cycle.
- clear_i=1 (any state) clears slot_valid_o and flags_o; slot contents are untouched. clear_i on the capture cycle: the clear applies first, then the capture sets its own valid bit and flags.
- Read:
  - rd_en_i=1 at edge N gives rd_valid_o=1 and rd_data_o=element at edge N+1, otherwise rd_valid_o=0.
  - rd_data_o holds its last value while rd_valid_o=0.
  - Reading an invalid slot returns 0 with rd_valid_o=1.
  - rd_row_i/rd_col_i >= MAX_DIM return 0.
  - A read and a capture to the same slot on the same edge return the OLD contents (read-before-write).
- c_matrix_o is combinational: slot[rd_target_i] if valid, else 0. Accumulating into an empty slot therefore adds zero.
- Reset mid-HOLD returns to IDLE. A finish_mul_i still high after reset release counts as a new rising edge and triggers a capture.

Optional Feature:
- Macro: OVF_STICKY_EN.
- Defined: on capture, flags_o <= flags_o | flags_i; flags accumulate across captures until clear_i or reset.
- Undefined: on capture, flags_o <= flags_i; only the last capture's flags are held.

Test Plan:
- Reset, then capture: finish_mul_i rises with wr_target_i=2 and c_matrix_i element(1,0)=16'h00FF. Required: slot_valid_o=4'b0100 one cycle later; finish_write_o=1 until finish_mul_i drops, then 0 the next cycle; a read of slot 2 (row 1, col 0) returns 16'h00FF one cycle after rd_en_i.
- finish_mul_i held high 5 cycles -> exactly one capture; changing wr_target_i during the hold does not set any other valid bit.
- Read an unwritten slot 3 -> rd_valid_o=1, rd_data_o=0. Set rd_target_i=3 -> c_matrix_o=0.
- Same-edge read and capture to slot 0 (old element 16'h0005, new 16'h0009) -> read returns 16'h0005; the next read returns 16'h0009.
- Two captures, flags_i=4'b0001 then 4'b1000:
  - With OVF_STICKY_EN, flags_o=4'b1001.
  - Without it, flags_o=4'b1000.
  - clear_i then gives flags_o=0 and slot_valid_o=0.
- Assert rst_ni=0 during HOLD -> all outputs 0 immediately. After release with finish_mul_i still high -> a new capture occurs and finish_write_o=1.
